// File: rtl/seg7_scan_driver.sv
// Holds a two-nibble value captured on load and scans it onto a common-anode
// 4-digit seven-segment display (ones, gap, tens, gap), all outputs active-low.
module seg7_scan_driver #(
  parameter int REFRESH_DIV     = 50000,
  parameter int GAP_CYCLES      = 16,
  parameter int LEAD_ZERO_BLANK = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] BCD_ten,
  input  logic [3:0] BCD_one,
  input  logic       load,
  input  logic       enable,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int CNT_MAX = (REFRESH_DIV > GAP_CYCLES) ?
                           ((REFRESH_DIV > 2) ? REFRESH_DIV : 2) :
                           ((GAP_CYCLES  > 2) ? GAP_CYCLES  : 2);
  localparam int CW = $clog2(CNT_MAX);
  localparam logic [CW-1:0] DIG_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit HAS_GAP = (GAP_CYCLES > 0);

  typedef enum logic [1:0] {S_ONE, S_GAP1, S_TEN, S_GAP2} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [3:0]      r_ten_q, r_one_q;
  logic [3:0]      r_an, w_an;
  logic [6:0]      r_seg, w_seg;
  logic            w_last;

  function automatic logic [6:0] dec(input logic [3:0] v);
    case (v)
      4'h0: dec = 7'b1000000;
      4'h1: dec = 7'b1111001;
      4'h2: dec = 7'b0100100;
      4'h3: dec = 7'b0110000;
      4'h4: dec = 7'b0011001;
      4'h5: dec = 7'b0010010;
      4'h6: dec = 7'b0000010;
      4'h7: dec = 7'b1111000;
      4'h8: dec = 7'b0000000;
      4'h9: dec = 7'b0010000;
      4'hA: dec = 7'b0001000;
      4'hB: dec = 7'b0000011;
      4'hC: dec = 7'b1000110;
      4'hD: dec = 7'b0100001;
      4'hE: dec = 7'b0000110;
      default: dec = 7'b0001110;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_ONE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_last      = (r_state == S_ONE || r_state == S_TEN) ? (r_cnt == DIG_LAST)
                                                         : (r_cnt == GAP_LAST);
    w_state_nxt = r_state;
    w_cnt_nxt   = w_last ? '0 : r_cnt + 1'b1;
    if (w_last) begin
      case (r_state)
        S_ONE:   w_state_nxt = HAS_GAP ? S_GAP1 : S_TEN;
        S_GAP1:  w_state_nxt = S_TEN;
        S_TEN:   w_state_nxt = HAS_GAP ? S_GAP2 : S_ONE;
        default: w_state_nxt = S_ONE;
      endcase
    end
  end

  // Enable only masks the drive; the scan keeps its phase underneath.
  always_comb begin
    w_an  = 4'b1111;
    w_seg = 7'b1111111;
    if (enable) begin
      case (r_state)
        S_ONE: begin
          w_an  = 4'b1110;
          w_seg = dec(r_one_q);
        end
        S_TEN: begin
          if (!(LEAD_ZERO_BLANK != 0 && r_ten_q == 4'h0)) begin
            w_an  = 4'b1101;
            w_seg = dec(r_ten_q);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ten_q <= 4'h0;
      r_one_q <= 4'h0;
      r_an    <= 4'b1111;
      r_seg   <= 7'b1111111;
    end else begin
      if (load) begin
        r_ten_q <= BCD_ten;
        r_one_q <= BCD_one;
      end
      r_an  <= w_an;
      r_seg <= w_seg;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Three configurations share one stimulus stream; each is checked against a
// phase-arithmetic model of the scan (slot derived from edges since reset).
module tb_seg7_scan_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] bcd_ten, bcd_one;
  logic       load, enable;

  logic [6:0] seg_a, seg_b, seg_c;
  logic       dp_a, dp_b, dp_c;
  logic [3:0] an_a, an_b, an_c;

  int checks   = 0;
  int failures = 0;
  int t;
  logic [3:0] m_ten, m_one;

  logic [6:0] DEC [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  always #5 clk = ~clk;

  seg7_scan_driver #(.REFRESH_DIV(4), .GAP_CYCLES(2), .LEAD_ZERO_BLANK(1)) u_main (
    .clk(clk), .reset(reset), .BCD_ten(bcd_ten), .BCD_one(bcd_one),
    .load(load), .enable(enable), .seg(seg_a), .dp(dp_a), .an(an_a));

  seg7_scan_driver #(.REFRESH_DIV(4), .GAP_CYCLES(2), .LEAD_ZERO_BLANK(0)) u_nlz (
    .clk(clk), .reset(reset), .BCD_ten(bcd_ten), .BCD_one(bcd_one),
    .load(load), .enable(enable), .seg(seg_b), .dp(dp_b), .an(an_b));

  seg7_scan_driver #(.REFRESH_DIV(4), .GAP_CYCLES(0), .LEAD_ZERO_BLANK(1)) u_ng (
    .clk(clk), .reset(reset), .BCD_ten(bcd_ten), .BCD_one(bcd_one),
    .load(load), .enable(enable), .seg(seg_c), .dp(dp_c), .an(an_c));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b t=%0d", tag, obs, exp, t);
    end
  endtask

  // Slot k of the scan is ones for k<R, tens for R+G<=k<2R+G, dark otherwise.
  task automatic model_out(input int r, input int g, input bit lzb, input int tt,
                           input logic [3:0] ten, input logic [3:0] one, input logic en,
                           output logic [3:0] e_an, output logic [6:0] e_seg);
    int p;
    p     = tt % (2*r + 2*g);
    e_an  = 4'b1111;
    e_seg = 7'b1111111;
    if (en) begin
      if (p < r) begin
        e_an  = 4'b1110;
        e_seg = DEC[one];
      end else if (p >= r + g && p < 2*r + g && !(lzb && ten == 4'h0)) begin
        e_an  = 4'b1101;
        e_seg = DEC[ten];
      end
    end
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, "_an_a"},  {4'h0, an_a},  8'h0F);
    chk({tag, "_seg_a"}, {1'b0, seg_a}, 8'h7F);
    chk({tag, "_an_b"},  {4'h0, an_b},  8'h0F);
    chk({tag, "_seg_b"}, {1'b0, seg_b}, 8'h7F);
    chk({tag, "_an_c"},  {4'h0, an_c},  8'h0F);
    chk({tag, "_seg_c"}, {1'b0, seg_c}, 8'h7F);
    chk({tag, "_dp"},    {5'h0, dp_a, dp_b, dp_c}, 8'h07);
  endtask

  // One clock: predict from pre-edge model state, advance, sample #1 after edge.
  task automatic step(input string tag);
    logic [3:0] ea, eb, ec;
    logic [6:0] sa, sb, sc;
    model_out(4, 2, 1'b1, t, m_ten, m_one, enable, ea, sa);
    model_out(4, 2, 1'b0, t, m_ten, m_one, enable, eb, sb);
    model_out(4, 0, 1'b1, t, m_ten, m_one, enable, ec, sc);
    if (load) begin
      m_ten = bcd_ten;
      m_one = bcd_one;
    end
    @(posedge clk);
    t++;
    #1;
    chk({tag, "_an_a"},  {4'h0, an_a},  {4'h0, ea});
    chk({tag, "_seg_a"}, {1'b0, seg_a}, {1'b0, sa});
    chk({tag, "_an_b"},  {4'h0, an_b},  {4'h0, eb});
    chk({tag, "_seg_b"}, {1'b0, seg_b}, {1'b0, sb});
    chk({tag, "_an_c"},  {4'h0, an_c},  {4'h0, ec});
    chk({tag, "_seg_c"}, {1'b0, seg_c}, {1'b0, sc});
  endtask

  task automatic do_load(input logic [3:0] ten, input logic [3:0] one, input string tag);
    bcd_ten = ten;
    bcd_one = one;
    load    = 1'b1;
    step(tag);
    load    = 1'b0;
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; enable = 1'b1; bcd_ten = 4'h0; bcd_one = 4'h0;
    t = 0; m_ten = 4'h0; m_one = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk_dark("reset");
    reset = 1'b1;

    // First scan after reset: ones shows 0, tens dark only with blanking on.
    repeat (12) step("post_reset");

    do_load(4'h4, 4'h2, "load42");
    repeat (24) step("scan42");

    do_load(4'hA, 4'hF, "loadAF");
    repeat (12) step("scanAF");

    do_load(4'h0, 4'h7, "load07");
    repeat (12) step("scan07");

    do_load(4'h3, 4'h9, "load39");
    bcd_ten = 4'h8; bcd_one = 4'h1;
    repeat (12) step("hold");

    enable = 1'b0;
    repeat (5) step("disabled");
    enable = 1'b1;
    repeat (12) step("reenabled");

    // Park u_main mid tens slot with a visible digit, then reset off-edge.
    do_load(4'h5, 4'h6, "load56");
    for (int i = 0; i < 12 && (t % 12) != 7; i++) step("seek_ten");
    chk("at_ten_an_a", {4'h0, an_a}, 8'h0D);
    reset = 1'b0;
    #2;
    chk_dark("async_reset");
    @(posedge clk);
    #1;
    chk_dark("reset_hold");
    reset = 1'b1;
    t = 0; m_ten = 4'h0; m_one = 4'h0;
    repeat (6) step("post_reset2");

    for (int i = 0; i < 160; i++) begin
      load    = ($urandom_range(0, 3) == 0);
      bcd_ten = 4'($urandom_range(0, 15));
      bcd_one = 4'($urandom_range(0, 15));
      enable  = ($urandom_range(0, 7) != 0);
      step("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
